// File: rtl/spell_mem_arbiter.sv
// spell_mem_arbiter
//   Shares the single spell_mem access port between the CPU core and the
//   debug/programming host. Arbitration is round-robin. dbg_lock locks the
//   CPU out. Each granted transaction is registered onto the mem_* port and
//   held there until mem_data_ready. The owner then gets a one-cycle ack with
//   the read data. If memory never answers, the access is aborted after
//   TIMEOUT_CYCLES select cycles.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/addr/wdata/type_data/write   CPU request (held until cpu_ack)
//   cpu_ack                      one-cycle completion pulse to the CPU
//   dbg_req/addr/wdata/type_data/write   debug request (held until dbg_ack)
//   dbg_ack                      one-cycle completion pulse to debug
//   dbg_lock                     1 = the CPU is never granted
//   rdata, rsp_timeout           response; valid only in the ack cycle
//   busy                         high while an access is in ACCESS or RELEASE
//   mem_select/write/type_data/addr/wdata   registered request to spell_mem
//   mem_rdata, mem_data_ready    response from spell_mem
module spell_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_type_data,
  input  logic       cpu_write,
  output logic       cpu_ack,
  input  logic       dbg_req,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  input  logic       dbg_type_data,
  input  logic       dbg_write,
  output logic       dbg_ack,
  input  logic       dbg_lock,
  output logic [7:0] rdata,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       mem_select,
  output logic       mem_write,
  output logic       mem_type_data,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_data_ready
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // The counter value seen on the last select cycle before an abort.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic        owner_dbg_reg;       // 1 = debug owns the current access
  logic        last_grant_dbg_reg;  // 1 = debug received the most recent grant
  logic [15:0] timeout_cnt_reg;

  logic cpu_eligible;
  logic dbg_eligible;
  logic grant_dbg;

  assign cpu_eligible = cpu_req & ~dbg_lock;
  assign dbg_eligible = dbg_req;
  // Debug wins when it is the only eligible requester. On a tie it wins
  // when the CPU had the previous grant.
  assign grant_dbg = dbg_eligible & (~cpu_eligible | ~last_grant_dbg_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      owner_dbg_reg      <= 1'b0;
      last_grant_dbg_reg <= 1'b1;  // the CPU wins the first tie
      timeout_cnt_reg    <= 16'd0;
      cpu_ack            <= 1'b0;
      dbg_ack            <= 1'b0;
      rdata              <= 8'd0;
      rsp_timeout        <= 1'b0;
      busy               <= 1'b0;
      mem_select         <= 1'b0;
      mem_write          <= 1'b0;
      mem_type_data      <= 1'b0;
      mem_addr           <= 8'd0;
      mem_wdata          <= 8'd0;
    end else begin
      // The ack and rsp_timeout signals are single-cycle pulses.
      // The rdata signal keeps its last value.
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      rsp_timeout <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (cpu_eligible || dbg_eligible) begin
            owner_dbg_reg      <= grant_dbg;
            last_grant_dbg_reg <= grant_dbg;
            timeout_cnt_reg    <= 16'd0;
            mem_select         <= 1'b1;
            busy               <= 1'b1;
            mem_write          <= grant_dbg ? dbg_write     : cpu_write;
            mem_type_data      <= grant_dbg ? dbg_type_data : cpu_type_data;
            mem_addr           <= grant_dbg ? dbg_addr      : cpu_addr;
            mem_wdata          <= grant_dbg ? dbg_wdata     : cpu_wdata;
            state_reg          <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          // Ready is tested first. When ready and the last allowed cycle
          // coincide, the access completes normally.
          if (mem_data_ready) begin
            rdata      <= mem_rdata;
            cpu_ack    <= ~owner_dbg_reg;
            dbg_ack    <= owner_dbg_reg;
            mem_select <= 1'b0;
            state_reg  <= ST_RELEASE;
          end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
            rdata       <= TIMEOUT_DATA;
            cpu_ack     <= ~owner_dbg_reg;
            dbg_ack     <= owner_dbg_reg;
            rsp_timeout <= 1'b1;
            mem_select  <= 1'b0;
            state_reg   <= ST_RELEASE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
          end
        end

        ST_RELEASE: begin
          // This state lasts one cycle. It gives spell_mem a guaranteed
          // deselect gap and is the cycle in which the ack is visible.
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          mem_select <= 1'b0;
          busy       <= 1'b0;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
`timescale 1ns/1ps
module tb_spell_mem_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_type_data = 1'b0, cpu_write = 1'b0;
  logic [7:0] cpu_addr = 8'd0, cpu_wdata = 8'd0;
  logic       dbg_req = 1'b0, dbg_type_data = 1'b0, dbg_write = 1'b0;
  logic [7:0] dbg_addr = 8'd0, dbg_wdata = 8'd0;
  logic       dbg_lock = 1'b0;
  logic       cpu_ack, dbg_ack, rsp_timeout, busy;
  logic       mem_select, mem_write, mem_type_data;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_data_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: ready is asserted on select cycle number mem_lat (0 = never)
  int         mem_lat = 1;
  int         sel_cnt = 0;
  logic [7:0] mem_array [512];
  logic       mon_bad = 1'b0;

  always #5 clk = ~clk;

  spell_mem_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_type_data(cpu_type_data), .cpu_write(cpu_write), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_type_data(dbg_type_data), .dbg_write(dbg_write), .dbg_ack(dbg_ack),
    .dbg_lock(dbg_lock), .rdata(rdata), .rsp_timeout(rsp_timeout), .busy(busy),
    .mem_select(mem_select), .mem_write(mem_write), .mem_type_data(mem_type_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_data_ready(mem_data_ready)
  );

  assign mem_rdata = mem_array[{mem_type_data, mem_addr}];

  always @(negedge clk) begin
    if (mem_select) begin
      sel_cnt        <= sel_cnt + 1;
      mem_data_ready <= (mem_lat != 0) && (sel_cnt + 1 == mem_lat);
    end else begin
      sel_cnt        <= 0;
      mem_data_ready <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (mem_select && mem_data_ready && mem_write)
      mem_array[{mem_type_data, mem_addr}] <= mem_wdata;
  end

  // Sticky flag: both acks together, or select outside a busy access
  always @(negedge clk) begin
    if (rst !== 1'b1 && ((cpu_ack === 1'b1 && dbg_ack === 1'b1) || (mem_select === 1'b1 && busy !== 1'b1)))
      mon_bad <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_cpu(input logic [7:0] a, input logic [7:0] w, input logic t, input logic wr);
    cpu_addr = a; cpu_wdata = w; cpu_type_data = t; cpu_write = wr; cpu_req = 1'b1;
  endtask

  task automatic set_dbg(input logic [7:0] a, input logic [7:0] w, input logic t, input logic wr);
    dbg_addr = a; dbg_wdata = w; dbg_type_data = t; dbg_write = wr; dbg_req = 1'b1;
  endtask

  // Observes one access. The call starts at a negedge. The task returns at
  // the negedge of the cycle after select falls, which is the ack cycle.
  // gap = IDLE cycles before select (-1 if none), sel = select cycles.
  // fields = {write,type,addr,wdata}. st = {busy,cpu_ack,dbg_ack,rsp_timeout}.
  task automatic run_access(output int gap, output int sel, output logic [17:0] fields,
                            output logic stable, output logic [3:0] st, output logic [7:0] rd);
    gap = 0; sel = 0; fields = '0; stable = 1'b1; st = '0; rd = '0;
    @(negedge clk);
    while (mem_select !== 1'b1 && gap < 8) begin
      gap++;
      @(negedge clk);
    end
    if (mem_select !== 1'b1) begin
      gap = -1;
      return;
    end
    fields = {mem_write, mem_type_data, mem_addr, mem_wdata};
    while (mem_select === 1'b1 && sel < 20) begin
      sel++;
      if ({mem_write, mem_type_data, mem_addr, mem_wdata} !== fields) stable = 1'b0;
      @(negedge clk);
    end
    st = {busy, cpu_ack, dbg_ack, rsp_timeout};
    rd = rdata;
    $display("txn t=%0t fields=%h sel_cycles=%0d st=%b rdata=%h", $time, fields, sel, st, rd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cpu_ack, dbg_ack, rsp_timeout, busy, mem_select, mem_write, mem_type_data,
         rdata, mem_addr, mem_wdata} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h expected 0", {cpu_ack, dbg_ack, rsp_timeout, busy,
               mem_select, mem_write, mem_type_data, rdata, mem_addr, mem_wdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int gap, sel; logic [17:0] f; logic stb; logic [3:0] st; logic [7:0] rd;
    mem_array[{1'b0, 8'h05}] = 8'h3C;
    mem_lat = 1;
    set_cpu(8'h05, 8'h00, 1'b0, 1'b0);
    run_access(gap, sel, f, stb, st, rd);
    cpu_req = 1'b0;
    n_checks++; if (gap !== 0) begin n_fail++; $display("FAIL single_read_grant_gap got %0d expected 0", gap); end
    n_checks++; if (sel !== 1) begin n_fail++; $display("FAIL single_read_select_cycles got %0d expected 1", sel); end
    n_checks++; if (f !== {2'b00, 8'h05, 8'h00}) begin n_fail++; $display("FAIL single_read_fields got %h expected %h", f, {2'b00, 8'h05, 8'h00}); end
    n_checks++; if (st !== 4'b1100) begin n_fail++; $display("FAIL single_read_ack got %b expected 1100", st); end
    n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL single_read_rdata got %h expected 3c", rd); end
    @(negedge clk);
    n_checks++;
    if ({mem_select, busy, cpu_ack, dbg_ack} !== 4'b0000) begin
      n_fail++; $display("FAIL single_read_idle got %b expected 0000", {mem_select, busy, cpu_ack, dbg_ack});
    end
  endtask

  task automatic test_round_robin();
    int gap, sel; logic [17:0] f; logic stb; logic [3:0] st; logic [7:0] rd;
    logic exp_dbg; logic [7:0] ea;
    do_reset();
    mem_array[{1'b0, 8'h10}] = 8'($urandom);
    mem_array[{1'b0, 8'h70}] = 8'($urandom);
    mem_lat = 1;
    set_cpu(8'h10, 8'h00, 1'b0, 1'b0);
    set_dbg(8'h70, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_access(gap, sel, f, stb, st, rd);
      exp_dbg = (k % 2 == 1);
      ea = exp_dbg ? 8'h70 : 8'h10;
      n_checks++;
      if (gap !== ((k == 0) ? 0 : 1) || sel !== 1) begin
        n_fail++; $display("FAIL rr_timing k=%0d got gap=%0d sel=%0d expected gap=%0d sel=1", k, gap, sel, (k == 0) ? 0 : 1);
      end
      n_checks++; if (f[15:8] !== ea) begin n_fail++; $display("FAIL rr_addr k=%0d got %h expected %h", k, f[15:8], ea); end
      n_checks++;
      if (st !== {1'b1, !exp_dbg, exp_dbg, 1'b0}) begin
        n_fail++; $display("FAIL rr_ack k=%0d got %b expected %b", k, st, {1'b1, !exp_dbg, exp_dbg, 1'b0});
      end
      n_checks++;
      if (rd !== mem_array[{1'b0, ea}]) begin
        n_fail++; $display("FAIL rr_rdata k=%0d got %h expected %h", k, rd, mem_array[{1'b0, ea}]);
      end
    end
    drive_idle();
  endtask

  task automatic test_lock();
    int gap, sel; logic [17:0] f; logic stb; logic [3:0] st; logic [7:0] rd;
    logic blocked;
    drive_idle();
    repeat (2) @(negedge clk);
    mem_lat = 1;
    dbg_lock = 1'b1;
    set_cpu(8'h11, 8'h00, 1'b0, 1'b0);
    set_dbg(8'h71, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      run_access(gap, sel, f, stb, st, rd);
      n_checks++;
      if (st !== 4'b1010 || f[15:8] !== 8'h71 || gap !== ((k == 0) ? 0 : 1)) begin
        n_fail++; $display("FAIL lock_dbg_only k=%0d got st=%b addr=%h gap=%0d expected st=1010 addr=71", k, st, f[15:8], gap);
      end
    end
    dbg_req = 1'b0;
    blocked = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_select !== 1'b0 || busy !== 1'b0) blocked = 1'b1;
    end
    n_checks++; if (blocked !== 1'b0) begin n_fail++; $display("FAIL lock_cpu_blocked got activity=%b expected 0", blocked); end
    set_dbg(8'h72, 8'h00, 1'b0, 1'b0);
    dbg_lock = 1'b0;
    run_access(gap, sel, f, stb, st, rd);
    n_checks++;
    if (st !== 4'b1100 || f[15:8] !== 8'h11 || gap !== 0) begin
      n_fail++; $display("FAIL lock_release_cpu got st=%b addr=%h gap=%0d expected st=1100 addr=11 gap=0", st, f[15:8], gap);
    end
    drive_idle();
  endtask

  task automatic test_timeout();
    int gap, sel; logic [17:0] f; logic stb; logic [3:0] st; logic [7:0] rd;
    @(negedge clk);
    mem_lat = 0;
    set_cpu(8'h33, 8'h00, 1'b0, 1'b0);
    run_access(gap, sel, f, stb, st, rd);
    cpu_req = 1'b0;
    mem_lat = TO;
    mem_array[{1'b1, 8'h44}] = 8'h5A;
    set_dbg(8'h44, 8'h00, 1'b1, 1'b0);
    n_checks++; if (gap !== 0 || sel !== TO) begin n_fail++; $display("FAIL timeout_cycles got gap=%0d sel=%0d expected gap=0 sel=%0d", gap, sel, TO); end
    n_checks++; if (st !== 4'b1101) begin n_fail++; $display("FAIL timeout_ack got %b expected 1101", st); end
    n_checks++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL timeout_rdata got %h expected ff", rd); end
    run_access(gap, sel, f, stb, st, rd);
    dbg_req = 1'b0;
    n_checks++; if (gap !== 1 || sel !== TO) begin n_fail++; $display("FAIL late_ready_cycles got gap=%0d sel=%0d expected gap=1 sel=%0d", gap, sel, TO); end
    n_checks++; if (st !== 4'b1010) begin n_fail++; $display("FAIL late_ready_ack got %b expected 1010", st); end
    n_checks++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL late_ready_rdata got %h expected 5a", rd); end
  endtask

  task automatic test_dbg_write();
    int gap, sel; logic [17:0] f; logic stb; logic [3:0] st; logic [7:0] rd;
    @(negedge clk);
    mem_lat = 3;
    mem_array[{1'b1, 8'h24}] = 8'h00;
    set_dbg(8'h24, 8'hA5, 1'b1, 1'b1);
    run_access(gap, sel, f, stb, st, rd);
    dbg_req = 1'b0;
    n_checks++; if (gap !== 0 || sel !== 3) begin n_fail++; $display("FAIL dbg_write_cycles got gap=%0d sel=%0d expected gap=0 sel=3", gap, sel); end
    n_checks++;
    if (f !== {1'b1, 1'b1, 8'h24, 8'hA5} || stb !== 1'b1) begin
      n_fail++; $display("FAIL dbg_write_fields got %h stable=%b expected %h stable=1", f, stb, {1'b1, 1'b1, 8'h24, 8'hA5});
    end
    n_checks++; if (st !== 4'b1010) begin n_fail++; $display("FAIL dbg_write_ack got %b expected 1010", st); end
    @(negedge clk);
    n_checks++;
    if (dbg_ack !== 1'b0 || mem_array[{1'b1, 8'h24}] !== 8'hA5) begin
      n_fail++; $display("FAIL dbg_write_single_ack got ack=%b mem=%h expected ack=0 mem=a5", dbg_ack, mem_array[{1'b1, 8'h24}]);
    end
  endtask

  task automatic test_reset_mid_access();
    int gap, sel; logic [17:0] f; logic stb; logic [3:0] st; logic [7:0] rd;
    @(negedge clk);
    mem_lat = 0;
    set_cpu(8'h50, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (mem_select !== 1'b1) begin n_fail++; $display("FAIL rst_mid_select got %b expected 1", mem_select); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_select, busy, cpu_ack, dbg_ack, rsp_timeout} !== 5'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs got %b expected 00000", {mem_select, busy, cpu_ack, dbg_ack, rsp_timeout});
    end
    set_dbg(8'h60, 8'h00, 1'b0, 1'b0);
    mem_lat = 1;
    rst = 1'b0;
    run_access(gap, sel, f, stb, st, rd);
    n_checks++;
    if (st !== 4'b1100 || f[15:8] !== 8'h50 || gap !== 0) begin
      n_fail++; $display("FAIL rst_mid_tie got st=%b addr=%h gap=%0d expected st=1100 addr=50 gap=0", st, f[15:8], gap);
    end
    drive_idle();
  endtask

  task automatic test_random();
    int gap, sel, lat; logic [17:0] f; logic stb; logic [3:0] st; logic [7:0] rd;
    logic cp, dp, ce, wd, to, last_dbg; logic [17:0] cf, df, ef; logic [7:0] exp_rd;
    do_reset();
    last_dbg = 1'b1;
    cp = 1'b0; dp = 1'b0; cf = '0; df = '0;
    for (int i = 0; i < 40; i++) begin
      if (!cp && $urandom_range(0, 1) == 1) begin cp = 1'b1; cf = 18'($urandom); end
      if (!dp && $urandom_range(0, 1) == 1) begin dp = 1'b1; df = 18'($urandom); end
      dbg_lock = ($urandom_range(0, 3) == 0);
      if (!dp && !(cp && !dbg_lock)) begin dp = 1'b1; df = 18'($urandom); end
      cpu_req = cp; {cpu_write, cpu_type_data, cpu_addr, cpu_wdata} = cf;
      dbg_req = dp; {dbg_write, dbg_type_data, dbg_addr, dbg_wdata} = df;
      lat = $urandom_range(1, 6);
      mem_lat = lat;
      // Reference: eligible set, then the requester that was not granted last
      ce = cp && !dbg_lock;
      if (ce && dp) wd = last_dbg ? 1'b0 : 1'b1;
      else          wd = !ce;
      ef = wd ? df : cf;
      to = (lat > TO);
      exp_rd = to ? 8'hFF : mem_array[ef[16:8]];
      run_access(gap, sel, f, stb, st, rd);
      n_checks++;
      if (gap !== ((i == 0) ? 0 : 1) || sel !== (to ? TO : lat)) begin
        n_fail++; $display("FAIL rand_timing i=%0d got gap=%0d sel=%0d expected gap=%0d sel=%0d", i, gap, sel, (i == 0) ? 0 : 1, to ? TO : lat);
      end
      n_checks++;
      if (f !== ef || stb !== 1'b1) begin
        n_fail++; $display("FAIL rand_fields i=%0d got %h stable=%b expected %h stable=1", i, f, stb, ef);
      end
      n_checks++;
      if (st !== {1'b1, !wd, wd, to}) begin
        n_fail++; $display("FAIL rand_ack i=%0d got %b expected %b", i, st, {1'b1, !wd, wd, to});
      end
      if (to || !ef[17]) begin
        n_checks++;
        if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata i=%0d got %h expected %h", i, rd, exp_rd); end
      end else begin
        n_checks++;
        if (mem_array[ef[16:8]] !== ef[7:0]) begin
          n_fail++; $display("FAIL rand_write i=%0d got mem=%h expected %h", i, mem_array[ef[16:8]], ef[7:0]);
        end
      end
      if (wd) dp = 1'b0; else cp = 1'b0;
      last_dbg = wd;
    end
    drive_idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem_array[a] = 8'($urandom);
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_timeout();
    test_dbg_write();
    test_reset_mid_access();
    test_random();
    n_checks++;
    if (mon_bad !== 1'b0) begin n_fail++; $display("FAIL invariants got violation=%b expected 0", mon_bad); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
